// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: ALU op codes and the operand forward-select encoding.
package cpu_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        A_NOP  = 4'd0,
        A_ADD  = 4'd1,
        A_SUB  = 4'd2,
        A_AND  = 4'd3,
        A_OR   = 4'd4,
        A_XOR  = 4'd5,
        A_NOR  = 4'd6,
        A_SLT  = 4'd7,
        A_SLTU = 4'd8,
        A_SLL  = 4'd9,
        A_SRA  = 4'd10,
        A_SRL  = 4'd11,
        A_LUI  = 4'd12
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_EXM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/fwd_sel_mux.sv
// Per-operand forwarding mux: picks EX/MEM result, MEM/WB data or the latched
// register value for one source index. Forwarding is compiled in only when the
// EX_FWD_EN macro is defined; otherwise the latched register value always wins.
module fwd_sel_mux
    import cpu_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic [RW-1:0] idx,
    input  logic [DW-1:0] reg_val,
    input  logic          exm_reg_write,
    input  logic [RW-1:0] exm_rd,
    input  logic [DW-1:0] exm_result,
    input  logic          wb_reg_write,
    input  logic [RW-1:0] wb_rd,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] fwd_val
);

    fwd_sel_e sel;

`ifdef EX_FWD_EN
    // Youngest producer first; register 0 is hard-wired and never forwarded.
    always_comb begin
        sel = FWD_REG;
        if (exm_reg_write && (exm_rd != '0) && (exm_rd == idx)) begin
            sel = FWD_EXM;
        end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == idx)) begin
            sel = FWD_WB;
        end
    end
`else
    // Without forwarding the hazard unit stalls RAW hazards, so sources are ignored.
    logic unused_fwd_srcs;
    assign unused_fwd_srcs = ^{idx, exm_reg_write, exm_rd, wb_reg_write, wb_rd};
    assign sel = FWD_REG;
`endif

    // Steer the selected source onto the operand.
    always_comb begin
        case (sel)
            FWD_EXM: fwd_val = exm_result;
            FWD_WB:  fwd_val = wb_data;
            default: fwd_val = reg_val;
        endcase
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-side operand forwarding for the 5-stage MIPS
// pipeline. Optional forwarding is controlled by the EX_FWD_EN macro.
module id_ex_operand_stage
    import cpu_pkg::*;
#(
    parameter int DW  = 32,
    parameter int RW  = 5,
    parameter int OPW = OP_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           stall,
    input  logic           flush,
    input  logic           id_valid,
    input  logic [DW-1:0]  id_rs_val,
    input  logic [DW-1:0]  id_rt_val,
    input  logic [RW-1:0]  id_rs,
    input  logic [RW-1:0]  id_rt,
    input  logic [RW-1:0]  id_rd,
    input  logic [DW-1:0]  id_imm,
    input  logic [4:0]     id_shamt,
    input  logic [OPW-1:0] id_alu_op,
    input  logic           id_src_a,
    input  logic           id_src_b,
    input  logic           id_reg_write,
    input  logic           id_mem_read,
    input  logic           id_mem_write,
    input  logic           exm_reg_write,
    input  logic [RW-1:0]  exm_rd,
    input  logic [DW-1:0]  exm_result,
    input  logic           wb_reg_write,
    input  logic [RW-1:0]  wb_rd,
    input  logic [DW-1:0]  wb_data,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic [OPW-1:0] alu_op,
    output logic [DW-1:0]  ex_store_data,
    output logic [RW-1:0]  ex_rd,
    output logic           ex_reg_write,
    output logic           ex_mem_read,
    output logic           ex_mem_write,
    output logic           ex_valid
);

    typedef struct packed {
        logic           valid;
        logic [DW-1:0]  rs_val;
        logic [DW-1:0]  rt_val;
        logic [RW-1:0]  rs;
        logic [RW-1:0]  rt;
        logic [RW-1:0]  rd;
        logic [DW-1:0]  imm;
        logic [4:0]     shamt;
        logic [OPW-1:0] alu_op;
        logic           src_a;
        logic           src_b;
        logic           reg_write;
        logic           mem_read;
        logic           mem_write;
    } idex_t;

    idex_t idex_d;
    idex_t idex_q;

    logic [DW-1:0] fwd_rs;
    logic [DW-1:0] fwd_rt;

    // Next-state of the ID/EX register: flush beats stall, stall beats load.
    always_comb begin
        idex_d = idex_q;
        if (flush) begin
            idex_d        = '0;
            idex_d.alu_op = OPW'(A_NOP);
        end else if (!stall) begin
            idex_d.valid     = id_valid;
            idex_d.rs_val    = id_rs_val;
            idex_d.rt_val    = id_rt_val;
            idex_d.rs        = id_rs;
            idex_d.rt        = id_rt;
            idex_d.rd        = id_rd;
            idex_d.imm       = id_imm;
            idex_d.shamt     = id_shamt;
            idex_d.alu_op    = id_alu_op;
            idex_d.src_a     = id_src_a;
            idex_d.src_b     = id_src_b;
            idex_d.reg_write = id_reg_write;
            idex_d.mem_read  = id_mem_read;
            idex_d.mem_write = id_mem_write;
        end
    end

    // ID/EX stage boundary; reset clears every stored field to a NOP bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    fwd_sel_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
        .idx           (idex_q.rs),
        .reg_val       (idex_q.rs_val),
        .exm_reg_write (exm_reg_write),
        .exm_rd        (exm_rd),
        .exm_result    (exm_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .fwd_val       (fwd_rs)
    );

    fwd_sel_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
        .idx           (idex_q.rt),
        .reg_val       (idex_q.rt_val),
        .exm_reg_write (exm_reg_write),
        .exm_rd        (exm_rd),
        .exm_result    (exm_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .fwd_val       (fwd_rt)
    );

    // Operand muxing; store data always takes the forwarded rt regardless of src_b.
    always_comb begin
        alu_a         = idex_q.src_a ? {{(DW-5){1'b0}}, idex_q.shamt} : fwd_rs;
        alu_b         = idex_q.src_b ? idex_q.imm : fwd_rt;
        alu_op        = idex_q.alu_op;
        ex_store_data = fwd_rt;
        ex_rd         = idex_q.rd;
        ex_valid      = idex_q.valid;
        ex_reg_write  = idex_q.reg_write & idex_q.valid;
        ex_mem_read   = idex_q.mem_read  & idex_q.valid;
        ex_mem_write  = idex_q.mem_write & idex_q.valid;
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed vector table, hand
// sequences for reset / stall / flush / live forwarding, and a randomized run
// against a behavioural model of the stage.
module tb_id_ex_operand_stage;

    localparam int DW  = 32;
    localparam int RW  = 5;
    localparam int OPW = 4;

`ifdef EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic           clk;
    logic           rst, stall, flush, id_valid;
    logic [DW-1:0]  id_rs_val, id_rt_val, id_imm;
    logic [RW-1:0]  id_rs, id_rt, id_rd;
    logic [4:0]     id_shamt;
    logic [OPW-1:0] id_alu_op;
    logic           id_src_a, id_src_b, id_reg_write, id_mem_read, id_mem_write;
    logic           exm_reg_write, wb_reg_write;
    logic [RW-1:0]  exm_rd, wb_rd;
    logic [DW-1:0]  exm_result, wb_data;
    logic [DW-1:0]  alu_a, alu_b, ex_store_data;
    logic [OPW-1:0] alu_op;
    logic [RW-1:0]  ex_rd;
    logic           ex_reg_write, ex_mem_read, ex_mem_write, ex_valid;

    id_ex_operand_stage #(.DW(DW), .RW(RW), .OPW(OPW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_imm(id_imm), .id_shamt(id_shamt), .id_alu_op(id_alu_op),
        .id_src_a(id_src_a), .id_src_b(id_src_b), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_valid(ex_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0]  rs_val, rt_val, imm;
        logic [RW-1:0]  rs, rt, rd;
        logic [4:0]     shamt;
        logic [OPW-1:0] op;
        logic           sa, sb, rw, mr, mw;
        logic           xw;
        logic [RW-1:0]  xrd;
        logic [DW-1:0]  xres;
        logic           ww;
        logic [RW-1:0]  wrd;
        logic [DW-1:0]  wdat;
        logic [DW-1:0]  e_a, e_b, e_sd;
        logic [OPW-1:0] e_op;
        logic [RW-1:0]  e_rd;
        logic           e_rw, e_mr, e_mw;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    // behavioural model of the latched instruction
    logic           m_valid, m_sa, m_sb, m_rw, m_mr, m_mw;
    logic [DW-1:0]  m_rs_val, m_rt_val, m_imm;
    logic [RW-1:0]  m_rs, m_rt, m_rd;
    logic [4:0]     m_shamt;
    logic [OPW-1:0] m_op;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rst = 0; stall = 0; flush = 0; id_valid = 0;
        id_rs_val = '0; id_rt_val = '0; id_imm = '0;
        id_rs = '0; id_rt = '0; id_rd = '0; id_shamt = '0; id_alu_op = '0;
        id_src_a = 0; id_src_b = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        exm_reg_write = 0; exm_rd = '0; exm_result = '0;
        wb_reg_write = 0; wb_rd = '0; wb_data = '0;
    endtask

    task automatic drive_vec(input vec_t v);
        stall = 0; flush = 0; id_valid = 1;
        id_rs_val = v.rs_val; id_rt_val = v.rt_val; id_imm = v.imm;
        id_rs = v.rs; id_rt = v.rt; id_rd = v.rd; id_shamt = v.shamt; id_alu_op = v.op;
        id_src_a = v.sa; id_src_b = v.sb;
        id_reg_write = v.rw; id_mem_read = v.mr; id_mem_write = v.mw;
        exm_reg_write = v.xw; exm_rd = v.xrd; exm_result = v.xres;
        wb_reg_write = v.ww; wb_rd = v.wrd; wb_data = v.wdat;
    endtask

    // spec-level forwarding rule applied to the live EX/MEM and MEM/WB inputs
    function automatic logic [DW-1:0] ref_fwd(input logic [RW-1:0] idx, input logic [DW-1:0] v);
        if (FWD && exm_reg_write && exm_rd != 0 && exm_rd == idx) return exm_result;
        if (FWD && wb_reg_write && wb_rd != 0 && wb_rd == idx) return wb_data;
        return v;
    endfunction

    vec_t vecs[8];

    initial begin
        vecs[0] = '{default: '0, rs: 1, rs_val: 5, rt: 2, rt_val: 7, op: 1, rw: 1, rd: 4,
                    e_a: 5, e_b: 7, e_sd: 7, e_op: 1, e_rd: 4, e_rw: 1};
        vecs[1] = '{default: '0, rs: 3, rs_val: 32'h11, rt: 6, rt_val: 32'h66, op: 1, rw: 1, rd: 3,
                    xw: 1, xrd: 3, xres: 32'hAA, ww: 1, wrd: 3, wdat: 32'hBB,
                    e_a: (FWD ? 32'hAA : 32'h11), e_b: 32'h66, e_sd: 32'h66, e_op: 1, e_rd: 3, e_rw: 1};
        vecs[2] = '{default: '0, rs: 3, rs_val: 32'h11, rt: 6, rt_val: 32'h66, op: 1, rw: 1, rd: 3,
                    xw: 0, xrd: 3, xres: 32'hAA, ww: 1, wrd: 3, wdat: 32'hBB,
                    e_a: (FWD ? 32'hBB : 32'h11), e_b: 32'h66, e_sd: 32'h66, e_op: 1, e_rd: 3, e_rw: 1};
        vecs[3] = '{default: '0, rs: 0, rs_val: 0, rt: 0, rt_val: 0, op: 1, rw: 1, rd: 2,
                    xw: 1, xrd: 0, xres: 32'h55, ww: 1, wrd: 0, wdat: 32'h77,
                    e_a: 0, e_b: 0, e_sd: 0, e_op: 1, e_rd: 2, e_rw: 1};
        vecs[4] = '{default: '0, rs: 7, rs_val: 32'h999, rt: 5, rt_val: 32'h10, sa: 1, shamt: 4,
                    op: 9, rw: 1, rd: 8,
                    e_a: 4, e_b: 32'h10, e_sd: 32'h10, e_op: 9, e_rd: 8, e_rw: 1};
        vecs[5] = '{default: '0, rs: 2, rs_val: 32'h100, rt: 9, rt_val: 32'h1, sb: 1, imm: 8,
                    op: 1, mw: 1, ww: 1, wrd: 9, wdat: 32'h1234,
                    e_a: 32'h100, e_b: 8, e_sd: (FWD ? 32'h1234 : 32'h1), e_op: 1, e_mw: 1};
        vecs[6] = '{default: '0, rs: 8, rs_val: 32'h2000, sb: 1, imm: 32'hFFFF_FFFC, op: 1,
                    mr: 1, rw: 1, rd: 10, xw: 1, xrd: 8, xres: 32'h3000,
                    e_a: (FWD ? 32'h3000 : 32'h2000), e_b: 32'hFFFF_FFFC, e_sd: 0,
                    e_op: 1, e_rd: 10, e_rw: 1, e_mr: 1};
        vecs[7] = '{default: '0, rs: 1, rs_val: 32'h40, rt: 12, rt_val: 3, op: 2, rw: 1, rd: 13,
                    xw: 1, xrd: 12, xres: 32'hDEAD, ww: 1, wrd: 12, wdat: 32'hBEEF,
                    e_a: 32'h40, e_b: (FWD ? 32'hDEAD : 32'h3), e_sd: (FWD ? 32'hDEAD : 32'h3),
                    e_op: 2, e_rd: 13, e_rw: 1};

        // reset held with a live instruction presented
        set_idle();
        rst = 1; id_valid = 1; id_alu_op = 1; id_reg_write = 1; id_rs_val = 32'h123; id_rs = 1;
        tick(); tick();
        chk("rst_valid", 32'(ex_valid), 0);
        chk("rst_op", 32'(alu_op), 0);
        chk("rst_rw", 32'(ex_reg_write), 0);
        chk("rst_a", alu_a, 0);
        chk("rst_b", alu_b, 0);
        chk("rst_rd", 32'(ex_rd), 0);
        chk("rst_sd", ex_store_data, 0);
        set_idle();

        // directed vector table
        for (int i = 0; i < 8; i++) begin
            drive_vec(vecs[i]);
            tick();
            chk($sformatf("v%0d_valid", i), 32'(ex_valid), 1);
            chk($sformatf("v%0d_a", i), alu_a, vecs[i].e_a);
            chk($sformatf("v%0d_b", i), alu_b, vecs[i].e_b);
            chk($sformatf("v%0d_sd", i), ex_store_data, vecs[i].e_sd);
            chk($sformatf("v%0d_op", i), 32'(alu_op), 32'(vecs[i].e_op));
            chk($sformatf("v%0d_rd", i), 32'(ex_rd), 32'(vecs[i].e_rd));
            chk($sformatf("v%0d_rw", i), 32'(ex_reg_write), 32'(vecs[i].e_rw));
            chk($sformatf("v%0d_mr", i), 32'(ex_mem_read), 32'(vecs[i].e_mr));
            chk($sformatf("v%0d_mw", i), 32'(ex_mem_write), 32'(vecs[i].e_mw));
        end

        // live forwarding while the stage is stalled
        set_idle();
        id_valid = 1; id_rs = 3; id_rs_val = 32'h11; id_alu_op = 1;
        tick();
        stall = 1; id_rs = 4; id_rs_val = 32'h44;
        exm_reg_write = 1; exm_rd = 3; exm_result = 32'hAA;
        wb_reg_write = 1; wb_rd = 3; wb_data = 32'hBB;
        #1 chk("live_exm", alu_a, FWD ? 32'hAA : 32'h11);
        exm_reg_write = 0;
        #1 chk("live_wb", alu_a, FWD ? 32'hBB : 32'h11);
        tick();
        chk("live_stall_wb", alu_a, FWD ? 32'hBB : 32'h11);
        wb_reg_write = 0;
        #1 chk("live_reg", alu_a, 32'h11);

        // stall holds for three cycles, then flush overrides stall
        set_idle();
        id_valid = 1; id_alu_op = 2; id_mem_write = 1; id_rd = 7;
        tick();
        stall = 1; id_alu_op = 5; id_rd = 9; id_mem_write = 0; id_rs_val = 32'h77;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("stall%0d_op", k), 32'(alu_op), 2);
            chk($sformatf("stall%0d_mw", k), 32'(ex_mem_write), 1);
            chk($sformatf("stall%0d_rd", k), 32'(ex_rd), 7);
        end
        flush = 1;
        tick();
        chk("flush_valid", 32'(ex_valid), 0);
        chk("flush_op", 32'(alu_op), 0);
        chk("flush_mw", 32'(ex_mem_write), 0);
        chk("flush_rw", 32'(ex_reg_write), 0);
        chk("flush_rd", 32'(ex_rd), 0);
        set_idle();

        // randomized run against the behavioural model
        rst = 1; tick(); rst = 0;
        m_valid = 0; m_sa = 0; m_sb = 0; m_rw = 0; m_mr = 0; m_mw = 0;
        m_rs_val = '0; m_rt_val = '0; m_imm = '0; m_rs = '0; m_rt = '0; m_rd = '0;
        m_shamt = '0; m_op = '0;
        for (int c = 0; c < 400; c++) begin
            rst   = ($urandom_range(0, 31) == 0);
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 4) == 0);
            id_valid = ($urandom_range(0, 3) != 0);
            id_rs_val = $urandom; id_rt_val = $urandom; id_imm = $urandom;
            id_rs = RW'($urandom_range(0, 3)); id_rt = RW'($urandom_range(0, 3));
            id_rd = RW'($urandom_range(0, 31)); id_shamt = 5'($urandom);
            id_alu_op = OPW'($urandom_range(0, 12));
            id_src_a = 1'($urandom); id_src_b = 1'($urandom);
            id_reg_write = 1'($urandom); id_mem_read = 1'($urandom); id_mem_write = 1'($urandom);
            exm_reg_write = 1'($urandom); exm_rd = RW'($urandom_range(0, 3)); exm_result = $urandom;
            wb_reg_write = 1'($urandom); wb_rd = RW'($urandom_range(0, 3)); wb_data = $urandom;
            if (rst) begin
                m_valid = 0; m_sa = 0; m_sb = 0; m_rw = 0; m_mr = 0; m_mw = 0;
                m_rs_val = '0; m_rt_val = '0; m_imm = '0; m_rs = '0; m_rt = '0; m_rd = '0;
                m_shamt = '0; m_op = '0;
            end else if (flush) begin
                m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_op = '0; m_rd = '0;
            end else if (!stall) begin
                m_valid = id_valid; m_rs_val = id_rs_val; m_rt_val = id_rt_val; m_imm = id_imm;
                m_rs = id_rs; m_rt = id_rt; m_rd = id_rd; m_shamt = id_shamt; m_op = id_alu_op;
                m_sa = id_src_a; m_sb = id_src_b;
                m_rw = id_reg_write; m_mr = id_mem_read; m_mw = id_mem_write;
            end
            tick();
            chk("rnd_valid", 32'(ex_valid), 32'(m_valid));
            chk("rnd_rw", 32'(ex_reg_write), 32'(m_rw && m_valid));
            chk("rnd_mr", 32'(ex_mem_read), 32'(m_mr && m_valid));
            chk("rnd_mw", 32'(ex_mem_write), 32'(m_mw && m_valid));
            chk("rnd_op", 32'(alu_op), 32'(m_op));
            chk("rnd_rd", 32'(ex_rd), 32'(m_rd));
            if (m_valid) begin
                chk("rnd_a", alu_a, m_sa ? 32'(m_shamt) : ref_fwd(m_rs, m_rs_val));
                chk("rnd_b", alu_b, m_sb ? m_imm : ref_fwd(m_rt, m_rt_val));
                chk("rnd_sd", ex_store_data, ref_fwd(m_rt, m_rt_val));
            end
        end

        set_idle();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
